// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Architectural PC register: async active-low reset to RESET_VAL, loads d when load=1.
module pc_reg #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch stage: one imem request at a time, hands inst/pc to execute.
// Optional alignment checking of next_pc is enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    output logic              inst_valid,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              exec_ack,
    input  logic              halt,
    output logic              fetch_err,
    output logic [1:0]        fsm_state
);

    // Handshakes: a request is accepted on a cycle with imem_req && imem_gnt; data is taken on
    // the first imem_rvalid at or after acceptance; inst is consumed on inst_valid && exec_ack.
    state_t state, state_next;
    logic   pc_load;
    logic   inst_load;

`ifdef FETCH_ALIGN_CHK_EN
    logic err_set;
    logic err_q;
`endif

    pc_reg #(
        .W         (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .d     (next_pc),
        .q     (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst <= '0;
        end else if (inst_load) begin
            inst <= imem_rdata;
        end
    end

    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        inst_load  = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        err_set    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
`ifdef FETCH_ALIGN_CHK_EN
                // Once an alignment error is seen the stage parks here until reset.
                if (err_q || pc[1:0] != 2'b00) begin
                    err_set = 1'b1;
                end else if (!halt) begin
                    state_next = S_REQ;
                end
`else
                if (!halt) begin
                    state_next = S_REQ;
                end
`endif
            end
            S_REQ: begin
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        inst_load  = 1'b1;
                        state_next = S_VALID;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    inst_load  = 1'b1;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                if (exec_ack) begin
`ifdef FETCH_ALIGN_CHK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        err_set    = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        pc_load    = 1'b1;
                        state_next = halt ? S_IDLE : S_REQ;
                    end
`else
                    pc_load    = 1'b1;
                    state_next = halt ? S_IDLE : S_REQ;
`endif
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef FETCH_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | err_set;
        end
    end
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign imem_req   = (state == S_REQ);
    assign imem_addr  = pc;
    assign inst_valid = (state == S_VALID);
    assign fsm_state  = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, randomized phase.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
    logic [31:0] next_pc = '0;
    logic        exec_ack = 1'b0;
    logic        halt = 1'b0;
    logic        fetch_err;
    logic [1:0]  fsm_state;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] exp_addr;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] npc;
        int          exp_dly;
    } vec_t;
    vec_t tbl[5];

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .pc          (pc),
        .inst_valid  (inst_valid),
        .next_pc     (next_pc),
        .exec_ack    (exec_ack),
        .halt        (halt),
        .fetch_err   (fetch_err),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        return (addr * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; exec_ack = 1'b0; halt = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        #1;
        check32("rst_pc", pc, RST_PC);
        check32("rst_addr", imem_addr, RST_PC);
        check32("rst_inst", inst, 32'h0);
        check1("rst_valid", inst_valid, 1'b0);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_err", fetch_err, 1'b0);
        check1("rst_state", fsm_state == S_IDLE, 1'b1);
        cyc();
    endtask

    // Entered on a negedge where a request should be visible; returns once inst_valid is seen.
    task automatic fetch_one(input logic [31:0] exp_addr, input int lat, input logic [31:0] data,
                             input logic halt_mid, input int exp_dly);
        int   dly;
        logic reissue;
        dly = 0;
        reissue = 1'b0;
        check1("req_present", imem_req, 1'b1);
        check32("req_addr", imem_addr, exp_addr);
        imem_gnt = 1'b1;
        if (lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = data;
        end
        for (int k = 1; k <= lat + 8; k++) begin
            cyc();
            imem_gnt = 1'b0;
            imem_rvalid = 1'b0;
            if (k == 1) halt = halt_mid;
            if (inst_valid) begin
                dly = k;
                break;
            end
            if (imem_req) reissue = 1'b1;
            if (k == lat) begin
                imem_rvalid = 1'b1;
                imem_rdata  = data;
            end
        end
        check32("valid_latency", dly, exp_dly);
        check32("inst_value", inst, data);
        check1("no_reissue", reissue, 1'b0);
    endtask

    task automatic ack_one(input logic [31:0] npc, input logic halt_v, input logic exp_req);
        exec_ack = 1'b1;
        next_pc  = npc;
        halt     = halt_v;
        cyc();
        exec_ack = 1'b0;
        check1("valid_drop", inst_valid, 1'b0);
        check32("pc_update", pc, npc);
        check1("req_after_ack", imem_req, exp_req);
        if (exp_req) check32("addr_after_ack", imem_addr, npc);
    endtask

    // Transaction-level model: addresses must follow the acked next_pc chain, data must follow memory.
    task automatic run_random(input int ncyc);
        logic [31:0] model_pc;
        logic        model_valid, outstanding, was_out, valid_new, got_data;
        logic        prev_halt, prev_acked, prev_req;
        logic [31:0] tmp;
        int          remain, acks;
        model_pc = RST_PC; model_valid = 1'b0; outstanding = 1'b0;
        prev_halt = 1'b0; prev_acked = 1'b0; prev_req = 1'b1;
        remain = 0; acks = 0;
        exp_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            check1("rnd_valid", inst_valid, model_valid);
            if (model_valid && exp_q.size() > 0) begin
                check32("rnd_inst", inst, exp_q[0]);
                check32("rnd_pc", pc, model_pc);
            end
            if (imem_req) begin
                check32("rnd_addr", imem_addr, model_pc);
                check1("rnd_req_single", outstanding | model_valid, 1'b0);
                if (!prev_req) check1("rnd_req_gated", prev_halt, 1'b0);
            end
            if (prev_acked && !prev_halt) check1("rnd_req_after_ack", imem_req, 1'b1);
            prev_req = imem_req;

            imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
            exec_ack = 1'b0; next_pc = $urandom;
            was_out = outstanding;
            got_data = 1'b0;
            if (imem_req && !outstanding && !model_valid) begin
                if ($urandom_range(0, 2) != 0) begin
                    imem_gnt = 1'b1;
                    exp_q.push_back(mem_fn(imem_addr));
                    remain = $urandom_range(0, 3);
                    outstanding = 1'b1;
                end
            end else if (!imem_req) begin
                imem_gnt = ($urandom_range(0, 3) == 0);
            end
            if (outstanding) begin
                if (remain == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = exp_q[$];
                    outstanding = 1'b0;
                    got_data = 1'b1;
                end else begin
                    remain--;
                end
            end
            if (!imem_req && !was_out && !got_data) imem_rvalid = ($urandom_range(0, 4) == 0);
            if (model_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    tmp = $urandom;
                    exec_ack = 1'b1;
                    next_pc = tmp & 32'hFFFF_FFFC;
                end
            end else begin
                exec_ack = ($urandom_range(0, 3) == 0);
            end
            halt = ($urandom_range(0, 3) == 0);

            valid_new = model_valid;
            prev_acked = model_valid && exec_ack;
            if (prev_acked) begin
                valid_new = 1'b0;
                model_pc = next_pc;
                void'(exp_q.pop_front());
                acks++;
            end
            if (got_data) valid_new = 1'b1;
            prev_halt = halt;
            model_valid = valid_new;
            cyc();
        end
        check1("rnd_progress", acks > 10, 1'b1);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; exec_ack = 1'b0; halt = 1'b0;
    endtask

    initial begin
        logic stable, saw_req;
        logic [31:0] hold_inst, hold_pc;

        tbl[0] = '{32'h0040_0000, 1, 32'h2008_0005, 32'h0040_0004, 2};
        tbl[1] = '{32'h0040_0004, 2, 32'h8C08_0000, 32'h0040_0008, 3};
        tbl[2] = '{32'h0040_0008, 0, 32'h1000_FFFF, 32'hFFFF_FFFC, 1};
        tbl[3] = '{32'hFFFF_FFFC, 3, 32'hAC09_0004, 32'h0000_0000, 4};
        tbl[4] = '{32'h0000_0000, 1, 32'h0800_0010, 32'h0040_0010, 2};

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fetch_one(tbl[i].exp_addr, tbl[i].lat, tbl[i].rdata, 1'b0, tbl[i].exp_dly);
            ack_one(tbl[i].npc, 1'b0, 1'b1);
        end

        // exec_ack withheld: outputs must hold and nothing new is fetched
        fetch_one(32'h0040_0010, 1, 32'h3C01_1234, 1'b0, 2);
        hold_inst = inst; hold_pc = pc; stable = 1'b1; saw_req = 1'b0;
        repeat (10) begin
            cyc();
            if (inst !== hold_inst || pc !== hold_pc || inst_valid !== 1'b1) stable = 1'b0;
            if (imem_req) saw_req = 1'b1;
        end
        check1("hold_stable", stable, 1'b1);
        check1("hold_no_req", saw_req, 1'b0);
        ack_one(32'h0040_0014, 1'b0, 1'b1);

        // halt raised while waiting on memory
        fetch_one(32'h0040_0014, 3, 32'h2402_0007, 1'b1, 4);
        ack_one(32'h0040_0018, 1'b1, 1'b0);
        saw_req = 1'b0;
        repeat (5) begin
            cyc();
            if (imem_req) saw_req = 1'b1;
        end
        check1("halt_no_req", saw_req, 1'b0);
        halt = 1'b0;
        cyc();
        check1("halt_release_req", imem_req, 1'b1);
        check32("halt_release_addr", imem_addr, 32'h0040_0018);

        // reset in S_WAIT, then a late rvalid
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        check1("wait_state", fsm_state == S_WAIT, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("async_rst_state", fsm_state == S_IDLE, 1'b1);
        cyc();
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        cyc();
        imem_rvalid = 1'b0;
        check1("late_rvalid_valid", inst_valid, 1'b0);
        check1("late_rvalid_req", imem_req, 1'b1);
        check32("late_rvalid_addr", imem_addr, RST_PC);

        run_random(2000);

        // misaligned next_pc
        do_reset();
        fetch_one(RST_PC, 1, 32'h0000_0020, 1'b0, 2);
        exec_ack = 1'b1;
        next_pc  = 32'h0040_0006;
        cyc();
        exec_ack = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        check1("align_err", fetch_err, 1'b1);
        check32("align_pc_kept", pc, RST_PC);
        saw_req = imem_req;
        repeat (5) begin
            cyc();
            if (imem_req) saw_req = 1'b1;
        end
        check1("align_no_req", saw_req, 1'b0);
        check1("align_err_sticky", fetch_err, 1'b1);
`else
        check1("noalign_err", fetch_err, 1'b0);
        check1("noalign_req", imem_req, 1'b1);
        check32("noalign_addr", imem_addr, 32'h0040_0006);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

endmodule
